// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: FWFT AXI4-Stream pixel buffer that drops on overflow and resyncs on the next SOF.
// Optional PIXEL_FIFO_STATS_EN adds ovf_count/frame_count statistics outputs.
module pixel_stream_fifo #(
   parameter int DEPTH = 16,
   parameter int DW    = 24
) (
   input  logic                     pixel_clk,
   input  logic                     reset,
   input  logic [DW-1:0]            s_tdata,
   input  logic                     s_tvalid,
   input  logic                     s_tuser,
   input  logic                     s_tlast,
   output logic [DW-1:0]            m_tdata,
   output logic                     m_tvalid,
   output logic                     m_tuser,
   output logic                     m_tlast,
   input  logic                     m_tready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clear_ovf,
   output logic                     drop_active
`ifdef PIXEL_FIFO_STATS_EN
   ,
   output logic [15:0]              ovf_count,
   output logic [15:0]              frame_count
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [0:0] WAIT_SOF = 1'b0;
   localparam logic [0:0] PASS     = 1'b1;

   logic [DW+1:0] mem [DEPTH];
   logic [DW+1:0] head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [0:0]    state;
   logic          pop, push, room, lost;

   always_comb begin
      head        = mem[rd_ptr];
      m_tvalid    = level != '0;
      {m_tuser, m_tlast, m_tdata} = m_tvalid ? head : '0;
      pop         = m_tvalid & m_tready;
      room        = (level < (AW+1)'(DEPTH)) | pop;
      push        = s_tvalid & room & ((state == PASS) | s_tuser);
      lost        = s_tvalid & ~room & (state == PASS);
      drop_active = state == WAIT_SOF;
   end

   // storage is deliberately unreset; outputs are masked while empty
   always_ff @(posedge pixel_clk)
      if (push) mem[wr_ptr] <= {s_tuser, s_tlast, s_tdata};

   always_ff @(posedge pixel_clk or posedge reset)
      if (reset) begin
         state    <= WAIT_SOF;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         state    <= lost ? WAIT_SOF : push ? PASS : state;
         wr_ptr   <= wr_ptr + AW'(push);
         rd_ptr   <= rd_ptr + AW'(pop);
         level    <= level + (AW+1)'(push) - (AW+1)'(pop);
         overflow <= lost | (overflow & ~clear_ovf);
      end

`ifdef PIXEL_FIFO_STATS_EN
   always_ff @(posedge pixel_clk or posedge reset)
      if (reset) begin
         ovf_count   <= '0;
         frame_count <= '0;
      end else if (clear_ovf) begin
         ovf_count   <= '0;
         frame_count <= '0;
      end else begin
         if (lost && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
         if (push && s_tuser) frame_count <= frame_count + 16'd1;
      end
`endif
endmodule
